// File: rtl/mac_accum_writeback.sv
// Two-stage signed multiply/accumulate stage that writes each completed dot
// product to sequential result addresses and pulses done after the last one.
module mac_accum_writeback #(
    parameter int DATA_W      = 8,
    parameter int DOT_LEN     = 8,
    parameter int NUM_RESULTS = 64,
    parameter int ADDR_W      = 6,
    parameter int ACC_W       = 19
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     mac_clr,
    input  logic                     load,
    input  logic signed [DATA_W-1:0] a_in,
    input  logic signed [DATA_W-1:0] b_in,
    output logic                     wr_en,
    output logic [ADDR_W-1:0]        wr_addr,
    output logic signed [ACC_W-1:0]  wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     err
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int TERM_W = $clog2(DOT_LEN + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t state_reg, state_next;

    logic signed [PROD_W-1:0] prod_reg;
    logic                     pv_reg;
    logic                     pclr_reg;

    logic signed [ACC_W-1:0]  acc_reg, acc_next;
    logic signed [ACC_W-1:0]  prod_ext;
    logic [TERM_W-1:0]        terms_reg, terms_next;
    logic                     complete;
    logic                     cmpl_reg;
    logic signed [ACC_W-1:0]  result_reg;

    logic [ADDR_W-1:0]        idx_reg;
    logic                     wr_en_reg;
    logic [ADDR_W-1:0]        wr_addr_reg;
    logic signed [ACC_W-1:0]  wr_data_reg;
    logic                     err_reg;

    logic in_run;
    logic last_write;

    assign in_run     = (state_reg == S_RUN);
    assign last_write = wr_en_reg && (wr_addr_reg == ADDR_W'(NUM_RESULTS - 1));

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN: begin
                // A restart outranks completion of the matrix.
                if (start)           state_next = S_RUN;
                else if (last_write) state_next = S_DONE;
            end
            S_DONE:  state_next = start ? S_RUN : S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- stage 1: multiply ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prod_reg <= '0;
            pv_reg   <= 1'b0;
            pclr_reg <= 1'b0;
        end else if (start || !in_run) begin
            pv_reg   <= 1'b0;
            pclr_reg <= 1'b0;
        end else begin
            prod_reg <= a_in * b_in;
            pv_reg   <= load;
            pclr_reg <= mac_clr;
        end
    end

    // ---------------- stage 2: accumulate ----------------
    assign prod_ext = {{(ACC_W - PROD_W){prod_reg[PROD_W-1]}}, prod_reg};

    always_comb begin
        acc_next   = acc_reg;
        terms_next = terms_reg;
        if (pclr_reg) begin
            acc_next   = pv_reg ? prod_ext : '0;
            terms_next = pv_reg ? TERM_W'(1) : '0;
        end else if (pv_reg) begin
            acc_next   = acc_reg + prod_ext;
            terms_next = terms_reg + TERM_W'(1);
        end
    end

    assign complete = pv_reg && (terms_next == TERM_W'(DOT_LEN));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_reg    <= '0;
            terms_reg  <= '0;
            cmpl_reg   <= 1'b0;
            result_reg <= '0;
        end else if (start) begin
            acc_reg   <= '0;
            terms_reg <= '0;
            cmpl_reg  <= 1'b0;
        end else if (complete) begin
            // Clear so the next dot product can enter with no bubble.
            acc_reg    <= '0;
            terms_reg  <= '0;
            cmpl_reg   <= 1'b1;
            result_reg <= acc_next;
        end else begin
            acc_reg   <= acc_next;
            terms_reg <= terms_next;
            cmpl_reg  <= 1'b0;
        end
    end

    // ---------------- write-back ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
            wr_data_reg <= '0;
        end else if (start) begin
            idx_reg     <= '0;
            wr_en_reg   <= 1'b0;
            wr_addr_reg <= '0;
        end else begin
            wr_en_reg <= cmpl_reg;
            if (cmpl_reg) begin
                wr_addr_reg <= idx_reg;
                wr_data_reg <= result_reg;
                idx_reg     <= idx_reg + ADDR_W'(1);
            end
        end
    end

    // ---------------- sticky error ----------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_reg <= 1'b0;
        end else if (start) begin
            err_reg <= 1'b0;
        end else if (load && !in_run) begin
            err_reg <= 1'b1;
        end
    end

    assign wr_en   = wr_en_reg;
    assign wr_addr = wr_addr_reg;
    assign wr_data = wr_data_reg;
    assign busy    = in_run;
    assign done    = (state_reg == S_DONE);
    assign err     = err_reg;

endmodule

// File: tb/tb_mac_accum_writeback.sv
// Self-checking bench for mac_accum_writeback: a per-cycle dot-product model
// predicts every write (address, value, edge) and each scenario task checks inline.
module tb_mac_accum_writeback;

    localparam int DATA_W      = 8;
    localparam int DOT_LEN     = 8;
    localparam int NUM_RESULTS = 64;
    localparam int ADDR_W      = 6;
    localparam int ACC_W       = 19;

    logic                     clk = 1'b0;
    logic                     reset;
    logic                     start;
    logic                     mac_clr;
    logic                     load;
    logic signed [DATA_W-1:0] a_in;
    logic signed [DATA_W-1:0] b_in;
    logic                     wr_en;
    logic [ADDR_W-1:0]        wr_addr;
    logic signed [ACC_W-1:0]  wr_data;
    logic                     busy;
    logic                     done;
    logic                     err;

    always #5 clk = ~clk;

    mac_accum_writeback #(
        .DATA_W(DATA_W), .DOT_LEN(DOT_LEN), .NUM_RESULTS(NUM_RESULTS),
        .ADDR_W(ADDR_W), .ACC_W(ACC_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .mac_clr(mac_clr), .load(load),
        .a_in(a_in), .b_in(b_in), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .busy(busy), .done(done), .err(err)
    );

    typedef struct {
        int addr;
        int data;
        int at_edge;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_x;

    int total = 0;
    int bad   = 0;
    int cycle_cnt = 0;

    // Reference model state: running dot product and result index.
    int m_terms, m_sum, m_idx;
    bit m_run, m_err;
    int last_exp_edge;

    int wr_count = 0;
    int done_pulses = 0;
    int last_addr = -1;
    int last_data = 0;

    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    // Drive one cycle of inputs at the falling edge and advance the model to
    // the rising edge that will sample them.
    task automatic drive(input bit st, input bit clr, input bit ld, input int a, input int b);
        int e;
        exp_t x;
        @(negedge clk);
        start   = st;
        mac_clr = clr;
        load    = ld;
        a_in    = a[DATA_W-1:0];
        b_in    = b[DATA_W-1:0];
        e = cycle_cnt + 1;
        if (st) begin
            m_run = 1; m_terms = 0; m_sum = 0; m_idx = 0; m_err = 0;
            for (int i = exp_q.size() - 1; i >= 0; i--)
                if (exp_q[i].at_edge >= e) exp_q.delete(i);
        end else begin
            if (ld && !m_run) m_err = 1;
            if (m_run) begin
                if (clr) begin
                    m_terms = 0; m_sum = 0;
                end
                if (ld) begin
                    m_sum = m_sum + a * b;
                    m_terms++;
                    if (m_terms == DOT_LEN) begin
                        x.addr = m_idx; x.data = m_sum; x.at_edge = e + 2;
                        exp_q.push_back(x);
                        last_exp_edge = e + 2;
                        m_idx++; m_terms = 0; m_sum = 0;
                        if (m_idx == NUM_RESULTS) m_run = 0;
                    end
                end
            end
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            drive(0, 0, 0, 0, 0);
            #1;
        end
        drive(0, 0, 0, 0, 0);
        #1;
    endtask

    // Scoreboard for the write port.
    always @(negedge clk) begin
        if (reset === 1'b1) begin
            while (exp_q.size() > 0 && exp_q[0].at_edge < cycle_cnt) begin
                total++; bad++;
                $display("FAIL missed_write got=none want addr=%0d data=%0d at edge %0d",
                         exp_q[0].addr, exp_q[0].data, exp_q[0].at_edge);
                void'(exp_q.pop_front());
            end
            if (wr_en === 1'b1) begin
                total++;
                wr_count++;
                last_addr = int'(wr_addr);
                last_data = int'(wr_data);
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_write got addr=%0d data=%0d edge=%0d want=no write",
                             wr_addr, wr_data, cycle_cnt);
                end else begin
                    mon_x = exp_q.pop_front();
                    if (wr_addr !== ADDR_W'(mon_x.addr) || wr_data !== ACC_W'(mon_x.data)
                        || cycle_cnt != mon_x.at_edge) begin
                        bad++;
                        $display("FAIL write got addr=%0d data=%0d edge=%0d want addr=%0d data=%0d edge=%0d",
                                 wr_addr, wr_data, cycle_cnt, mon_x.addr, mon_x.data, mon_x.at_edge);
                    end
                end
            end
            if (done === 1'b1) done_pulses++;
        end
    end

    task automatic test_reset();
        reset = 1'b0; start = 0; mac_clr = 0; load = 0; a_in = '0; b_in = '0;
        m_run = 0; m_err = 0; m_terms = 0; m_sum = 0; m_idx = 0;
        repeat (3) @(negedge clk);
        #1;
        total++;
        if ({wr_en, wr_addr, wr_data, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got en=%b addr=%0d data=%0d busy=%b done=%b err=%b want all 0",
                     wr_en, wr_addr, wr_data, busy, done, err);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic();
        int wc0;
        wc0 = wr_count;
        drive(1, 0, 0, 0, 0);
        #1;
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL busy_before_start got=%b want=0", busy);
        end
        for (int i = 1; i <= 8; i++) begin
            drive(0, 0, 1, i, 1);
            if (i == 1) begin
                #1;
                total++;
                if (busy !== 1'b1) begin
                    bad++; $display("FAIL busy_after_start got=%b want=1", busy);
                end
            end
        end
        drain();
        total++;
        if (exp_q.size() != 0 || wr_count - wc0 != 1 || last_data != 36 || last_addr != 0) begin
            bad++;
            $display("FAIL basic_dot got writes=%0d addr=%0d data=%0d want writes=1 addr=0 data=36",
                     wr_count - wc0, last_addr, last_data);
        end
    endtask

    task automatic test_signed();
        drive(1, 0, 0, 0, 0);
        repeat (8) drive(0, 0, 1, -128, -128);
        drain();
        total++;
        if (last_data != 131072 || last_addr != 0) begin
            bad++;
            $display("FAIL signed_max got addr=%0d data=%0d want addr=0 data=131072", last_addr, last_data);
        end
        repeat (8) drive(0, 0, 1, -128, 127);
        drain();
        total++;
        if (last_data != -130048 || last_addr != 1) begin
            bad++;
            $display("FAIL signed_min got addr=%0d data=%0d want addr=1 data=-130048", last_addr, last_data);
        end
    endtask

    task automatic test_clr_abort();
        int wc0;
        drive(1, 0, 0, 0, 0);
        wc0 = wr_count;
        repeat (3) drive(0, 0, 1, 5, 5);
        drive(0, 1, 1, 2, 3);
        repeat (7) drive(0, 0, 1, 2, 3);
        drain();
        total++;
        if (wr_count - wc0 != 1 || last_data != 48 || last_addr != 0) begin
            bad++;
            $display("FAIL clr_abort got writes=%0d addr=%0d data=%0d want writes=1 addr=0 data=48",
                     wr_count - wc0, last_addr, last_data);
        end
    endtask

    task automatic test_full_matrix();
        int wc0, f;
        drive(1, 0, 0, 0, 0);
        wc0 = wr_count;
        done_pulses = 0;
        repeat (NUM_RESULTS * DOT_LEN) drive(0, 0, 1, 1, 1);
        f = last_exp_edge;
        for (int i = 0; i < 10 && cycle_cnt < f + 1; i++) begin
            drive(0, 0, 0, 0, 0);
            #1;
        end
        total++;
        if (cycle_cnt != f + 1 || done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL done_pulse got edge=%0d done=%b busy=%b want edge=%0d done=1 busy=0",
                     cycle_cnt, done, busy, f + 1);
        end
        drive(0, 0, 0, 0, 0);
        #1;
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL done_width got done=%b busy=%b want 0 0", done, busy);
        end
        total++;
        if (wr_count - wc0 != NUM_RESULTS || done_pulses != 1 || last_addr != NUM_RESULTS - 1
            || exp_q.size() != 0) begin
            bad++;
            $display("FAIL full_matrix got writes=%0d pulses=%0d last_addr=%0d want 64 1 63",
                     wr_count - wc0, done_pulses, last_addr);
        end
    endtask

    task automatic test_err();
        int wc0;
        wc0 = wr_count;
        drive(0, 0, 1, 3, 3);
        repeat (4) drive(0, 0, 0, 0, 0);
        #1;
        total++;
        if (err !== m_err || err !== 1'b1 || wr_count != wc0) begin
            bad++;
            $display("FAIL err_set got err=%b writes=%0d want err=1 writes=0", err, wr_count - wc0);
        end
        drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        #1;
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++; $display("FAIL err_clear got err=%b busy=%b want err=0 busy=1", err, busy);
        end
    endtask

    task automatic test_restart();
        int wc0;
        drive(1, 0, 0, 0, 0);
        wc0 = wr_count;
        repeat (12) drive(0, 0, 1, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        drive(1, 0, 0, 0, 0);
        repeat (8) drive(0, 0, 1, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        drain();
        total++;
        if (wr_count - wc0 != 2 || last_addr != 0) begin
            bad++;
            $display("FAIL restart got writes=%0d last_addr=%0d want writes=2 last_addr=0",
                     wr_count - wc0, last_addr);
        end
    endtask

    task automatic test_random();
        int wc0;
        bit ld, clr;
        drive(1, 0, 0, 0, 0);
        wc0 = wr_count;
        for (int i = 0; i < 400 && m_idx < 40; i++) begin
            ld  = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 15) == 0);
            drive(0, clr, ld, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        end
        drain();
        total++;
        if (wr_count - wc0 != m_idx || exp_q.size() != 0) begin
            bad++;
            $display("FAIL random_writes got=%0d want=%0d", wr_count - wc0, m_idx);
        end
    endtask

    task automatic test_reset_midrun();
        int wc0;
        drive(1, 0, 0, 0, 0);
        repeat (20) drive(0, 0, 1, $urandom_range(0, 255) - 128, $urandom_range(0, 255) - 128);
        @(negedge clk);
        reset = 1'b0;
        load = 0; start = 0; mac_clr = 0;
        #1;
        total++;
        if ({wr_en, wr_addr, wr_data, busy, done, err} !== '0) begin
            bad++;
            $display("FAIL reset_midrun got en=%b addr=%0d data=%0d busy=%b done=%b err=%b want all 0",
                     wr_en, wr_addr, wr_data, busy, done, err);
        end
        exp_q.delete();
        m_run = 0; m_err = 0; m_terms = 0; m_sum = 0; m_idx = 0;
        wc0 = wr_count;
        @(negedge clk);
        reset = 1'b1;
        repeat (12) drive(0, 0, 0, 0, 0);
        #1;
        total++;
        if (wr_count != wc0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL post_reset got writes=%0d busy=%b want writes=0 busy=0", wr_count - wc0, busy);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout at edge %0d", cycle_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_signed();
        test_clr_abort();
        test_full_matrix();
        test_err();
        test_restart();
        test_random();
        test_reset_midrun();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
